// File: rtl/adder_tree_sched.sv
// Round-robin scheduler sharing one pipelined five-operand adder tree among NREQ requesters.
// Tags ride alongside the tree so each sum is returned to the requester that issued it.
module adder_tree_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int LAT   = 3,
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW   = $clog2(LAT + 2)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*5*WIDTH-1:0]   req_ops,
    output logic [NREQ-1:0]           gnt,
    output logic [WIDTH-1:0]          tree_a,
    output logic [WIDTH-1:0]          tree_b,
    output logic [WIDTH-1:0]          tree_c,
    output logic [WIDTH-1:0]          tree_d,
    output logic [WIDTH-1:0]          tree_e,
    input  logic [WIDTH-1:0]          tree_out,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [WIDTH-1:0]          rsp_data,
    output logic [IDW-1:0]            rsp_id,
    output logic [CW-1:0]             in_flight,
    output logic                      busy
);

    logic [WIDTH-1:0] ops_arr [NREQ][5];
    logic [IDW-1:0]   rr_ptr_reg;
    logic [NREQ-1:0]  masked_req;
    logic             gnt_any;
    logic [IDW-1:0]   gnt_id;
    logic [IDW-1:0]   search_idx;

    logic             tag_valid_reg [LAT];
    logic [IDW-1:0]   tag_id_reg    [LAT];

    logic [NREQ-1:0]  rsp_valid_reg;
    logic [WIDTH-1:0] rsp_data_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic [CW-1:0]    in_flight_reg;
    logic [CW-1:0]    in_flight_next;

    genvar gi, gj;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            for (gj = 0; gj < 5; gj++) begin : g_op
                assign ops_arr[gi][gj] = req_ops[(gi*5+gj)*WIDTH +: WIDTH];
            end
        end
    endgenerate

    // Reset low also masks requests so no grant is visible while held in reset.
    always_comb begin
        masked_req = req & {NREQ{en & reset}};
        gnt_any    = 1'b0;
        gnt_id     = '0;
        search_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            search_idx = IDW'((int'(rr_ptr_reg) + i) % NREQ);
            if (!gnt_any && masked_req[search_idx]) begin
                gnt_any = 1'b1;
                gnt_id  = search_idx;
            end
        end
    end

    assign gnt = gnt_any ? (NREQ'(1) << gnt_id) : '0;

    always_comb begin
        tree_a = '0;
        tree_b = '0;
        tree_c = '0;
        tree_d = '0;
        tree_e = '0;
        if (gnt_any) begin
            tree_a = ops_arr[gnt_id][0];
            tree_b = ops_arr[gnt_id][1];
            tree_c = ops_arr[gnt_id][2];
            tree_d = ops_arr[gnt_id][3];
            tree_e = ops_arr[gnt_id][4];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr_reg       <= '0;
            tag_valid_reg[0] <= 1'b0;
            tag_id_reg[0]    <= '0;
        end else begin
            tag_valid_reg[0] <= gnt_any;
            tag_id_reg[0]    <= gnt_id;
            if (gnt_any)
                rr_ptr_reg <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
        end
    end

    generate
        for (gi = 1; gi < LAT; gi++) begin : g_tag
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    tag_valid_reg[gi] <= 1'b0;
                    tag_id_reg[gi]    <= '0;
                end else begin
                    tag_valid_reg[gi] <= tag_valid_reg[gi-1];
                    tag_id_reg[gi]    <= tag_id_reg[gi-1];
                end
            end
        end
    endgenerate

    // One op enters on a grant; the op held in the response register leaves each edge.
    assign in_flight_next = in_flight_reg + CW'(gnt_any) - CW'(|rsp_valid_reg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_reg <= '0;
            rsp_id_reg    <= '0;
            rsp_data_reg  <= '0;
            in_flight_reg <= '0;
        end else begin
            rsp_valid_reg <= tag_valid_reg[LAT-1] ? (NREQ'(1) << tag_id_reg[LAT-1]) : '0;
            rsp_id_reg    <= tag_id_reg[LAT-1];
            if (tag_valid_reg[LAT-1])
                rsp_data_reg <= tree_out;
            in_flight_reg <= in_flight_next;
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_id    = rsp_id_reg;
    assign in_flight = in_flight_reg;
    assign busy      = (in_flight_reg != '0);

endmodule

// File: tb/tb_adder_tree_sched.sv
// Randomised bench for adder_tree_sched: a behavioural tree, a round-robin model and a
// response scoreboard checked by an independent monitor.
module tb_adder_tree_sched;
    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int LAT   = 3;
    localparam int IDW   = 2;
    localparam int CW    = $clog2(LAT + 2);

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    en = 1'b0;
    logic [NREQ-1:0]         req = '0;
    logic [NREQ*5*WIDTH-1:0] req_ops = '0;
    logic [NREQ-1:0]         gnt;
    logic [WIDTH-1:0]        tree_a, tree_b, tree_c, tree_d, tree_e, tree_out;
    logic [NREQ-1:0]         rsp_valid;
    logic [WIDTH-1:0]        rsp_data;
    logic [IDW-1:0]          rsp_id;
    logic [CW-1:0]           in_flight;
    logic                    busy;

    adder_tree_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .clk(clk), .reset(reset), .en(en), .req(req), .req_ops(req_ops), .gnt(gnt),
        .tree_a(tree_a), .tree_b(tree_b), .tree_c(tree_c), .tree_d(tree_d), .tree_e(tree_e),
        .tree_out(tree_out), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id),
        .in_flight(in_flight), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the external adder tree: LAT register stages.
    logic [WIDTH-1:0] tree_pipe [LAT];
    always @(posedge clk) begin
        tree_pipe[0] <= tree_a + tree_b + tree_c + tree_d + tree_e;
        for (int j = 1; j < LAT; j++) tree_pipe[j] <= tree_pipe[j-1];
    end
    assign tree_out = tree_pipe[LAT-1];

    typedef struct {
        int               id;
        logic [WIDTH-1:0] sum;
        int               due;
    } exp_t;
    exp_t q[$];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Requester model state
    bit               act  [NREQ];
    bit               keep [NREQ];
    logic [WIDTH-1:0] ops  [NREQ][5];
    int               rr_m = 0;

    task automatic new_op(input int k, input int mode);
        for (int o = 0; o < 5; o++) begin
            case (mode)
                1:       ops[k][o] = '1;
                2:       ops[k][o] = '0;
                3:       ops[k][o] = WIDTH'(o + 1);
                default: ops[k][o] = WIDTH'($urandom);
            endcase
        end
        act[k] = 1'b1;
    endtask

    task automatic pack();
        for (int k = 0; k < NREQ; k++) begin
            req[k] = act[k];
            for (int o = 0; o < 5; o++) req_ops[(k*5+o)*WIDTH +: WIDTH] = ops[k][o];
        end
    endtask

    // Called at posedge+1: drive, check the grant after the falling edge, advance.
    task automatic step();
        int g;
        logic [WIDTH-1:0] s;
        pack();
        #5;
        g = -1;
        if (reset && en) begin
            for (int i = 0; i < NREQ; i++) begin
                if (g < 0 && act[(rr_m + i) % NREQ]) g = (rr_m + i) % NREQ;
            end
        end
        chk("gnt", 64'(gnt), (g < 0) ? 64'd0 : (64'd1 << g));
        if (g < 0) begin
            chk("tree_idle", 64'(tree_a | tree_b | tree_c | tree_d | tree_e), 64'd0);
        end else begin
            s = '0;
            for (int o = 0; o < 5; o++) s = s + ops[g][o];
            q.push_back('{id: g, sum: s, due: cyc + LAT + 1});
            rr_m = (g + 1) % NREQ;
            if (keep[g]) new_op(g, 0);
            else act[g] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drop_all();
        for (int k = 0; k < NREQ; k++) begin
            act[k] = 1'b0;
            keep[k] = 1'b0;
        end
    endtask

    // Monitor: compares presented responses against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rsp_valid_reset", 64'(rsp_valid), 64'd0);
                chk("in_flight_reset", 64'(in_flight), 64'd0);
            end else begin
                chk("in_flight", 64'(in_flight), 64'(q.size()));
                chk("busy", 64'(busy), 64'(q.size() != 0));
                if (rsp_valid != '0) begin
                    if (q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL spurious_rsp: got rsp_valid=%b expected none", rsp_valid);
                    end else begin
                        e = q.pop_front();
                        chk("rsp_onehot", 64'(rsp_valid), 64'd1 << e.id);
                        chk("rsp_id", 64'(rsp_id), 64'(e.id));
                        chk("rsp_data", 64'(rsp_data), 64'(e.sum));
                        chk("rsp_cycle", 64'(cyc), 64'(e.due));
                        $display("[TB] rsp id=%0d data=%h cycle=%0d", rsp_id, rsp_data, cyc);
                    end
                end else if (q.size() != 0 && q[0].due <= cyc) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_rsp: got none expected id=%0d data=%h", q[0].id, q[0].sum);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int bound;
        drop_all();
        for (int k = 0; k < NREQ; k++) for (int o = 0; o < 5; o++) ops[k][o] = '0;
        // Reset state, with requests present to show grants are blocked
        req = '1;
        en  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("gnt_in_reset", 64'(gnt), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_in_flight", 64'(in_flight), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b1;

        // Single request 1..5 on requester 2
        new_op(2, 3);
        step();
        repeat (6) step();

        // All requesters held continuously
        for (int k = 0; k < NREQ; k++) begin new_op(k, 0); keep[k] = 1'b1; end
        repeat (12) step();
        drop_all();
        repeat (6) step();

        // Overflow and zero operands
        new_op(0, 1);
        step();
        new_op(1, 2);
        step();
        repeat (6) step();

        // Issue gating mid-stream
        for (int k = 0; k < NREQ; k++) begin new_op(k, 0); keep[k] = 1'b1; end
        repeat (4) step();
        en = 1'b0;
        repeat (3) step();
        en = 1'b1;
        repeat (4) step();
        en = 1'b0;
        repeat (6) step();
        en = 1'b1;
        drop_all();

        // Reset with three operations in flight
        for (int k = 0; k < NREQ; k++) begin new_op(k, 0); keep[k] = 1'b1; end
        repeat (3) step();
        reset = 1'b0;
        q.delete();
        rr_m = 0;
        #1;
        chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("midrst_in_flight", 64'(in_flight), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_rsp_data", 64'(rsp_data), 64'd0);
        repeat (2) step();
        reset = 1'b1;
        repeat (2) step();
        drop_all();
        repeat (6) step();

        // Wrap and fairness: bring rr to 3 via requester 2, then hold 0 and 3
        new_op(2, 0);
        step();
        new_op(0, 0); keep[0] = 1'b1;
        new_op(3, 0); keep[3] = 1'b1;
        repeat (6) step();
        drop_all();
        repeat (6) step();

        // Random traffic
        for (int n = 0; n < 300; n++) begin
            en = ($urandom_range(0, 7) != 0);
            for (int k = 0; k < NREQ; k++) begin
                if (!act[k] && $urandom_range(0, 1) == 1) begin
                    new_op(k, 0);
                    keep[k] = ($urandom_range(0, 1) == 1);
                end
            end
            step();
        end
        drop_all();
        en = 1'b1;

        bound = 0;
        while (q.size() != 0 && bound < 20) begin
            step();
            bound++;
        end
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
